// File: rtl/bcd_adder8_pkg.sv
// rtl/bcd_adder8_pkg.sv - shared display codes, FSM encoding and BCD digit limit
package bcd_adder8_pkg;
   localparam logic [2:0] SHOWA     = 3'd0;
   localparam logic [2:0] SHOWB     = 3'd1;
   localparam logic [2:0] SHOWCIN   = 3'd2;
   localparam logic [2:0] SHOWRSLT  = 3'd3;
   localparam logic [2:0] SHOWBLNKS = 3'd5;
   localparam logic [2:0] SHOWERR   = 3'd6;

   localparam logic [2:0] ST_ENT_A   = 3'd0;
   localparam logic [2:0] ST_ENT_B   = 3'd1;
   localparam logic [2:0] ST_ENT_CIN = 3'd2;
   localparam logic [2:0] ST_CALC    = 3'd3;
   localparam logic [2:0] ST_RSLT_S  = 3'd4;
   localparam logic [2:0] ST_ERR     = 3'd5;

   localparam logic [3:0] BCD_MAX = 4'd9;

   function automatic logic bcd_ok(input logic [7:0] v);
      return (v[7:4] <= BCD_MAX) && (v[3:0] <= BCD_MAX);
   endfunction
endpackage

// File: rtl/bcd_adder8_ctl_if.sv
// rtl/bcd_adder8_ctl_if.sv - operand/result bundle between controller and external BCD adder
interface bcd_adder8_ctl_if;
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic       op_cin;
   logic [7:0] add_sum;
   logic       add_cout;

   modport master (output op_a, output op_b, output op_cin, input add_sum, input add_cout);
   modport slave  (input op_a, input op_b, input op_cin, output add_sum, output add_cout);
endinterface

// File: rtl/bcd_adder8_ctl_key_pulse.sv
// rtl/bcd_adder8_ctl_key_pulse.sv - 2-flop key synchronizer with falling-edge pulse
module key_pulse (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic pulse
);
   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q, prev_d;

   always_comb begin
      sync1_d = key_n;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   // Reset to released so a key already low at reset exit still yields one edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
      end
   end

   assign pulse = prev_q & ~sync2_q;
endmodule

// File: rtl/bcd_adder8_ctl.sv
// rtl/bcd_adder8_ctl.sv - operand entry FSM, result register and display select for the BCD adder
module bcd_adder8_ctl
   import bcd_adder8_pkg::*;
#(
   parameter int BLINK_CYCLES = 25_000_000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [9:0]               SW,
   input  logic                     key_enter_n,
   input  logic                     key_clear_n,
   bcd_adder8_ctl_if.master         add_if,
   output logic [11:0]              RSLT,
   output logic [2:0]               out_mux_sel
);
   localparam int CW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_CYCLES - 1);

   logic enter_p, clear_p;
   logic unused_sw;
   assign unused_sw = ^SW[9:8];

   key_pulse u_enter (.clk(clk), .reset(reset), .key_n(key_enter_n), .pulse(enter_p));
   key_pulse u_clear (.clk(clk), .reset(reset), .key_n(key_clear_n), .pulse(clear_p));

   logic [2:0]    state_q, state_d;
   logic [7:0]    op_a_q, op_a_d;
   logic [7:0]    op_b_q, op_b_d;
   logic          op_cin_q, op_cin_d;
   logic [11:0]   rslt_q, rslt_d;
   logic [CW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_err_q, blink_err_d;

   always_comb begin
      state_d  = state_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      op_cin_d = op_cin_q;
      rslt_d   = rslt_q;
      if (clear_p) begin
         state_d  = ST_ENT_A;
         op_a_d   = 8'h00;
         op_b_d   = 8'h00;
         op_cin_d = 1'b0;
         rslt_d   = 12'h000;
      end else begin
         case (state_q)
            ST_ENT_A:
               if (enter_p) begin
                  if (bcd_ok(SW[7:0])) begin
                     op_a_d  = SW[7:0];
                     state_d = ST_ENT_B;
                  end else begin
                     state_d = ST_ERR;
                  end
               end
            ST_ENT_B:
               if (enter_p) begin
                  if (bcd_ok(SW[7:0])) begin
                     op_b_d  = SW[7:0];
                     state_d = ST_ENT_CIN;
                  end else begin
                     state_d = ST_ERR;
                  end
               end
            ST_ENT_CIN:
               if (enter_p) begin
                  op_cin_d = SW[0];
                  state_d  = ST_CALC;
               end
            ST_CALC: begin
               rslt_d  = {3'b000, add_if.add_cout, add_if.add_sum};
               state_d = ST_RSLT_S;
            end
            ST_RSLT_S, ST_ERR:
               if (enter_p) state_d = ST_ENT_A;
            default: state_d = ST_ENT_A;
         endcase
      end
   end

   // Outside ERR the counter is parked at zero/SHOWERR, so ERR entry always starts a fresh phase.
   always_comb begin
      blink_cnt_d = '0;
      blink_err_d = 1'b1;
      if (state_q == ST_ERR) begin
         if (blink_cnt_q == CNT_MAX) begin
            blink_cnt_d = '0;
            blink_err_d = ~blink_err_q;
         end else begin
            blink_cnt_d = blink_cnt_q + CW'(1);
            blink_err_d = blink_err_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_ENT_A;
         op_a_q      <= 8'h00;
         op_b_q      <= 8'h00;
         op_cin_q    <= 1'b0;
         rslt_q      <= 12'h000;
         blink_cnt_q <= '0;
         blink_err_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         op_cin_q    <= op_cin_d;
         rslt_q      <= rslt_d;
         blink_cnt_q <= blink_cnt_d;
         blink_err_q <= blink_err_d;
      end
   end

   always_comb begin
      out_mux_sel = SHOWA;
      case (state_q)
         ST_ENT_A:   out_mux_sel = SHOWA;
         ST_ENT_B:   out_mux_sel = SHOWB;
         ST_ENT_CIN: out_mux_sel = SHOWCIN;
         ST_CALC:    out_mux_sel = SHOWBLNKS;
         ST_RSLT_S:  out_mux_sel = SHOWRSLT;
         ST_ERR:     out_mux_sel = blink_err_q ? SHOWERR : SHOWBLNKS;
         default:    out_mux_sel = SHOWA;
      endcase
   end

   assign add_if.op_a   = op_a_q;
   assign add_if.op_b   = op_b_q;
   assign add_if.op_cin = op_cin_q;
   assign RSLT          = rslt_q;
endmodule

// File: tb/tb_bcd_adder8_ctl.sv
// tb/tb_bcd_adder8_ctl.sv - directed scoreboard bench for bcd_adder8_ctl
module tb_bcd_adder8_ctl;
   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  SW;
   logic        key_enter_n;
   logic        key_clear_n;
   logic [11:0] RSLT;
   logic [2:0]  out_mux_sel;

   int compared = 0;
   int mismatched = 0;
   logic [11:0] exp_q[$];

   bcd_adder8_ctl_if add_if ();

   bcd_adder8_ctl #(.BLINK_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .SW(SW),
      .key_enter_n(key_enter_n), .key_clear_n(key_clear_n),
      .add_if(add_if.master), .RSLT(RSLT), .out_mux_sel(out_mux_sel)
   );

   always #5 clk = ~clk;

   // External BCD adder: digit-wise add with +6 correction.
   always_comb begin
      logic [4:0] lo, hi;
      logic       c;
      lo = {1'b0, add_if.op_a[3:0]} + {1'b0, add_if.op_b[3:0]} + {4'b0, add_if.op_cin};
      c  = 1'b0;
      if (lo > 5'd9) begin lo = lo + 5'd6; c = 1'b1; end
      hi = {1'b0, add_if.op_a[7:4]} + {1'b0, add_if.op_b[7:4]} + {4'b0, c};
      c  = 1'b0;
      if (hi > 5'd9) begin hi = hi + 5'd6; c = 1'b1; end
      add_if.add_sum  = {hi[3:0], lo[3:0]};
      add_if.add_cout = c;
   end

   function automatic logic [11:0] bcd_expected(input logic [7:0] a, input logic [7:0] b, input logic cin);
      int s;
      logic [11:0] r;
      s = int'(a[7:4]) * 10 + int'(a[3:0]) + int'(b[7:4]) * 10 + int'(b[3:0]) + int'(cin);
      r = 12'h000;
      r[8]   = (s >= 100);
      r[7:4] = 4'((s % 100) / 10);
      r[3:0] = 4'(s % 10);
      return r;
   endfunction

   task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Press keys at a negedge; sel checked 2, 3 and 4 samples later (4'hF skips the first).
   task automatic press(input bit ent, input bit clr, input logic [3:0] exp_old,
                        input logic [3:0] exp_new, input logic [3:0] exp_after, input string tag);
      if (ent) key_enter_n = 1'b0;
      if (clr) key_clear_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      if (exp_old != 4'hF) check({tag, " sel_before"}, 12'(out_mux_sel), 12'(exp_old));
      @(negedge clk);
      check({tag, " sel_new"}, 12'(out_mux_sel), 12'(exp_new));
      @(negedge clk);
      check({tag, " sel_after"}, 12'(out_mux_sel), 12'(exp_after));
      key_enter_n = 1'b1;
      key_clear_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic pop_check(input string tag);
      logic [11:0] e;
      if (exp_q.size() == 0) begin
         compared++;
         mismatched++;
         $error("FAIL %s: observed empty scoreboard expected an entry", tag);
      end else begin
         e = exp_q.pop_front();
         check(tag, RSLT, e);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      SW = 10'h000;
      key_enter_n = 1'b1;
      key_clear_n = 1'b1;
      repeat (3) @(negedge clk);
      check("reset sel", 12'(out_mux_sel), 12'(3'd0));
      check("reset rslt", RSLT, 12'h000);
      check("reset op_a", 12'(add_if.op_a), 12'h000);
      check("reset op_b", 12'(add_if.op_b), 12'h000);
      check("reset op_cin", 12'(add_if.op_cin), 12'h000);
      reset = 1'b0;
      @(negedge clk);
      check("post reset sel", 12'(out_mux_sel), 12'(3'd0));

      SW = 10'h045;
      press(1, 0, 0, 1, 1, "t1 A");
      check("t1 op_a", 12'(add_if.op_a), 12'h045);
      SW = 10'h037;
      press(1, 0, 1, 2, 2, "t1 B");
      check("t1 op_b", 12'(add_if.op_b), 12'h037);
      SW = 10'h001;
      exp_q.push_back(bcd_expected(8'h45, 8'h37, 1'b1));
      press(1, 0, 2, 5, 3, "t1 cin");
      pop_check("t1 rslt");
      check("t1 op_cin", 12'(add_if.op_cin), 12'h001);
      press(1, 0, 3, 0, 0, "t1 back");
      check("t1 rslt held", RSLT, 12'h083);

      SW = 10'h399;
      press(1, 0, 0, 1, 1, "t2 A");
      press(1, 0, 1, 2, 2, "t2 B");
      SW = 10'h001;
      exp_q.push_back(bcd_expected(8'h99, 8'h99, 1'b1));
      press(1, 0, 2, 5, 3, "t2 cin");
      pop_check("t2 rslt");
      press(1, 0, 3, 0, 0, "t2 back");
      check("t2 rslt held", RSLT, 12'h199);

      SW = 10'h03A;
      press(1, 0, 0, 6, 6, "t3 bad A");
      check("t3 op_a kept", 12'(add_if.op_a), 12'h099);
      for (int k = 0; k < 12; k++) begin
         check($sformatf("t3 blink %0d", k), 12'(out_mux_sel),
               (((4 + k) / 4) % 2 == 0) ? 12'd6 : 12'd5);
         @(negedge clk);
      end
      press(1, 0, 4'hF, 0, 0, "t3 exit");

      SW = 10'h012;
      press(1, 0, 0, 1, 1, "t4 A");
      SW = 10'h034;
      press(1, 0, 1, 2, 2, "t4 B");
      press(1, 1, 2, 0, 0, "t4 clr+ent");
      check("t4 op_a", 12'(add_if.op_a), 12'h000);
      check("t4 op_b", 12'(add_if.op_b), 12'h000);
      check("t4 rslt", RSLT, 12'h000);
      repeat (3) @(negedge clk);
      check("t4 stay A", 12'(out_mux_sel), 12'(3'd0));

      SW = 10'h021;
      press(1, 0, 0, 1, 1, "t5 A");
      SW = 10'h011;
      press(1, 0, 1, 2, 2, "t5 B");
      SW = 10'h001;
      key_enter_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("t5 sel cin", 12'(out_mux_sel), 12'(3'd2));
      @(negedge clk);
      check("t5 sel calc", 12'(out_mux_sel), 12'(3'd5));
      reset = 1'b1;
      key_enter_n = 1'b1;
      @(negedge clk);
      check("t5 rslt no load", RSLT, 12'h000);
      check("t5 sel reset", 12'(out_mux_sel), 12'(3'd0));
      check("t5 op_a reset", 12'(add_if.op_a), 12'h000);
      reset = 1'b0;
      @(negedge clk);
      check("t5 sel after", 12'(out_mux_sel), 12'(3'd0));

      SW = 10'h050;
      key_enter_n = 1'b0;
      repeat (100) @(negedge clk);
      check("t6 held sel", 12'(out_mux_sel), 12'(3'd1));
      check("t6 held op_a", 12'(add_if.op_a), 12'h050);
      key_enter_n = 1'b1;
      repeat (5) @(negedge clk);
      check("t6 released sel", 12'(out_mux_sel), 12'(3'd1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
